// File: rtl/theta_seq.sv
// Sequential Keccak-f theta step: accumulates column parity one plane per
// cycle, then applies D one plane per cycle, and hands the state to rho.
module theta_seq #(
  parameter  int Z_WIDTH    = 64,
  localparam int STATE_SIZE = 25 * Z_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [0:STATE_SIZE-1] IN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [0:STATE_SIZE-1] OUT,
  output logic [1:0]            FSM_STATE
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a source holds valid and data stable until that edge, and a
  // sink may raise or drop ready at will.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PARITY = 2'd1,
    APPLY  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         y_q, y_d;
  logic [Z_WIDTH-1:0] lane_q [25];
  logic [Z_WIDTH-1:0] lane_d [25];
  logic [Z_WIDTH-1:0] c_q [5];
  logic [Z_WIDTH-1:0] c_d [5];
  logic [Z_WIDTH-1:0] d_lane [5];
  logic [Z_WIDTH-1:0] in_lane [25];
  logic               accept;

  // Lane z index is the bit offset inside its lane; this shifts every bit up
  // by one with wrap, so bit z of the result is bit z-1 of the source.
  function automatic logic [Z_WIDTH-1:0] rot_up(input logic [Z_WIDTH-1:0] v);
    logic [Z_WIDTH-1:0] r;
    r = '0;
    for (int z = 0; z < Z_WIDTH; z++) begin
      r[z] = v[(z + Z_WIDTH - 1) % Z_WIDTH];
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 25; i++) begin
      for (int z = 0; z < Z_WIDTH; z++) begin
        in_lane[i][z] = IN[i*Z_WIDTH + z];
      end
    end
  end

  always_comb begin
    OUT = '0;
    for (int i = 0; i < 25; i++) begin
      for (int z = 0; z < Z_WIDTH; z++) begin
        OUT[i*Z_WIDTH + z] = lane_q[i][z];
      end
    end
  end

  always_comb begin
    for (int x = 0; x < 5; x++) begin
      d_lane[x] = c_q[(x + 4) % 5] ^ rot_up(c_q[(x + 1) % 5]);
    end
  end

  assign IN_READY  = RST_N & ((state_q == IDLE) | ((state_q == DONE) & OUT_READY));
  assign OUT_VALID = RST_N & (state_q == DONE);
  assign FSM_STATE = state_q;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    lane_d  = lane_q;
    c_d     = c_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (IN_VALID) accept = 1'b1;
      end
      PARITY: begin
        for (int i = 0; i < 25; i++) begin
          if (y_q == 3'(i / 5)) c_d[i % 5] = c_d[i % 5] ^ lane_q[i];
        end
        if (y_q == 3'd4) begin
          y_d     = 3'd0;
          state_d = APPLY;
        end else begin
          y_d = y_q + 3'd1;
        end
      end
      APPLY: begin
        for (int i = 0; i < 25; i++) begin
          if (y_q == 3'(i / 5)) lane_d[i] = lane_q[i] ^ d_lane[i % 5];
        end
        if (y_q == 3'd4) begin
          y_d     = 3'd0;
          state_d = DONE;
        end else begin
          y_d = y_q + 3'd1;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          if (IN_VALID) accept = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Accepting a new state restarts the parity pass from a clean column sum.
    if (accept) begin
      lane_d  = in_lane;
      c_d     = '{default: '0};
      y_d     = 3'd0;
      state_d = PARITY;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      y_q     <= 3'd0;
      lane_q  <= '{default: '0};
      c_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      lane_q  <= lane_d;
      c_q     <= c_d;
    end
  end

  a_out_stable: assert property (@(posedge CLK) disable iff (!RST_N)
    (OUT_VALID && !OUT_READY) |=> (OUT_VALID && $stable(OUT)));

  a_busy_not_ready: assert property (@(posedge CLK)
    ((state_q == PARITY) || (state_q == APPLY)) |-> !IN_READY);

endmodule
